// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ARM condition codes and {N,Z,C,V} flag bit positions.
// Used by cond_check and cond_unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Condition-field evaluation against the registered {N,Z,C,V} flags.
// Purely combinational.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] iCond,
  input  logic [3:0] iFlags,
  output logic       oCondEx
);

  logic n, z, c, v;

  always_comb begin
    n = iFlags[FLAG_N];
    z = iFlags[FLAG_Z];
    c = iFlags[FLAG_C];
    v = iFlags[FLAG_V];
    oCondEx = 1'b0;
    unique case (cond_e'(iCond))
      COND_EQ: oCondEx = z;
      COND_NE: oCondEx = !z;
      COND_CS: oCondEx = c;
      COND_CC: oCondEx = !c;
      COND_MI: oCondEx = n;
      COND_PL: oCondEx = !n;
      COND_VS: oCondEx = v;
      COND_VC: oCondEx = !v;
      COND_HI: oCondEx = c & !z;
      COND_LS: oCondEx = !c | z;
      COND_GE: oCondEx = (n == v);
      COND_LT: oCondEx = (n != v);
      COND_GT: oCondEx = !z & (n == v);
      COND_LE: oCondEx = z | (n != v);
      COND_AL: oCondEx = 1'b1;
      COND_NV: oCondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: flag register, write gating, exec/skip stats.
// Define COND_UNIT_STATS_EN to build the statistics counters.
module cond_unit
  import cpu_pkg::*;
(
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEn,
  input  logic [3:0]  iCond,
  input  logic [3:0]  iALUFlags,
  input  logic [1:0]  iFlagW,
  input  logic        iPCS,
  input  logic        iRegW,
  input  logic        iMemW,
  input  logic        iStatClr,
  output logic        oPCSrc,
  output logic        oRegWrite,
  output logic        oMemWrite,
  output logic        oCondEx,
  output logic [3:0]  oFlags,
  output logic [15:0] oExecCnt,
  output logic [15:0] oSkipCnt
);

  logic [3:0] flags_q, flags_d;
  logic       commit;

  cond_check u_cond_check (
    .iCond   (iCond),
    .iFlags  (flags_q),
    .oCondEx (oCondEx)
  );

  assign commit    = iEn & oCondEx;
  assign oPCSrc    = iPCS  & commit;
  assign oRegWrite = iRegW & commit;
  assign oMemWrite = iMemW & commit;
  assign oFlags    = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (commit && iFlagW[1]) begin
      flags_d[FLAG_N] = iALUFlags[FLAG_N];
      flags_d[FLAG_Z] = iALUFlags[FLAG_Z];
    end
    if (commit && iFlagW[0]) begin
      flags_d[FLAG_C] = iALUFlags[FLAG_C];
      flags_d[FLAG_V] = iALUFlags[FLAG_V];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) flags_q <= '0;
    else      flags_q <= flags_d;
  end

`ifdef COND_UNIT_STATS_EN
  logic [15:0] exec_cnt_q, exec_cnt_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;

  // Clear wins over increment; counters stick at all-ones.
  always_comb begin
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (iStatClr) begin
      exec_cnt_d = '0;
      skip_cnt_d = '0;
    end else if (iEn) begin
      if (oCondEx) begin
        if (exec_cnt_q != 16'hFFFF) exec_cnt_d = exec_cnt_q + 16'd1;
      end else begin
        if (skip_cnt_q != 16'hFFFF) skip_cnt_d = skip_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign oExecCnt = exec_cnt_q;
  assign oSkipCnt = skip_cnt_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = iStatClr;
  assign oExecCnt = '0;
  assign oSkipCnt = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit.
// Counter expectations follow COND_UNIT_STATS_EN.
module tb_cond_unit;

`ifdef COND_UNIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        iClk = 1'b0;
  logic        iRst, iEn, iPCS, iRegW, iMemW, iStatClr;
  logic [3:0]  iCond, iALUFlags;
  logic [1:0]  iFlagW;
  logic        oPCSrc, oRegWrite, oMemWrite, oCondEx;
  logic [3:0]  oFlags;
  logic [15:0] oExecCnt, oSkipCnt;

  int n_cmp = 0;
  int n_bad = 0;
  int e_exec = 0;
  int e_skip = 0;

  cond_unit dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iEn       (iEn),
    .iCond     (iCond),
    .iALUFlags (iALUFlags),
    .iFlagW    (iFlagW),
    .iPCS      (iPCS),
    .iRegW     (iRegW),
    .iMemW     (iMemW),
    .iStatClr  (iStatClr),
    .oPCSrc    (oPCSrc),
    .oRegWrite (oRegWrite),
    .oMemWrite (oMemWrite),
    .oCondEx   (oCondEx),
    .oFlags    (oFlags),
    .oExecCnt  (oExecCnt),
    .oSkipCnt  (oSkipCnt)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".exec"}, oExecCnt, STATS ? 16'(e_exec) : 16'h0);
    chk({tag, ".skip"}, oSkipCnt, STATS ? 16'(e_skip) : 16'h0);
  endtask

  task automatic drive(input logic en, input logic [3:0] cond,
                       input logic [1:0] fw, input logic [3:0] alu);
    iEn = en;
    iCond = cond;
    iFlagW = fw;
    iALUFlags = alu;
    #1;
  endtask

  initial begin
    iRst = 1'b1; iEn = 1'b0; iPCS = 1'b0; iRegW = 1'b0;
    iMemW = 1'b0; iStatClr = 1'b0; iCond = 4'hE;
    iALUFlags = 4'h0; iFlagW = 2'b00;
    tick();
    tick();
    iRst = 1'b0;
    #1;
    chk("rst.flags", 16'(oFlags), 16'h0);
    chk_cnt("rst");
    drive(1'b0, 4'h0, 2'b00, 4'h0);
    chk("rst.eq", 16'(oCondEx), 16'h0);
    drive(1'b0, 4'h1, 2'b00, 4'h0);
    chk("rst.ne", 16'(oCondEx), 16'h1);
    drive(1'b0, 4'hE, 2'b00, 4'h0);
    chk("rst.al", 16'(oCondEx), 16'h1);

    // flag update then EQ uses it
    drive(1'b1, 4'hE, 2'b11, 4'b0100);
    chk("upd.own_cond", 16'(oCondEx), 16'h1);
    tick(); e_exec++;
    chk("upd.flags", 16'(oFlags), 16'h4);
    iRegW = 1'b1;
    drive(1'b1, 4'h0, 2'b00, 4'h0);
    chk("eq.condex", 16'(oCondEx), 16'h1);
    chk("eq.regwrite", 16'(oRegWrite), 16'h1);
    tick(); e_exec++;
    chk_cnt("eq");
    iRegW = 1'b0;

    // NE fails: nothing gated, flags untouched
    iPCS = 1'b1; iMemW = 1'b1;
    drive(1'b1, 4'h1, 2'b11, 4'b1010);
    chk("ne.pcsrc", 16'(oPCSrc), 16'h0);
    chk("ne.memwrite", 16'(oMemWrite), 16'h0);
    tick(); e_skip++;
    chk("ne.flags", 16'(oFlags), 16'h4);
    chk_cnt("ne");

    // AL passes with PCS/MemW
    drive(1'b1, 4'hE, 2'b11, 4'b0000);
    chk("al.pcsrc", 16'(oPCSrc), 16'h1);
    chk("al.memwrite", 16'(oMemWrite), 16'h1);
    tick(); e_exec++;
    iPCS = 1'b0; iMemW = 1'b0;
    chk("clr.flags", 16'(oFlags), 16'h0);

    // C/V-only update
    drive(1'b1, 4'hE, 2'b01, 4'b1111);
    tick(); e_exec++;
    chk("part.cv", 16'(oFlags), 16'h3);
    drive(1'b1, 4'hE, 2'b10, 4'b1100);
    tick(); e_exec++;
    chk("part.nz", 16'(oFlags), 16'hF);
    drive(1'b1, 4'hE, 2'b11, 4'b0000);
    tick(); e_exec++;
    chk("part.zero", 16'(oFlags), 16'h0);

    // stall
    iRegW = 1'b1;
    drive(1'b0, 4'hE, 2'b11, 4'b1111);
    chk("stall.regwrite", 16'(oRegWrite), 16'h0);
    tick();
    chk("stall.flags", 16'(oFlags), 16'h0);
    chk_cnt("stall");
    iRegW = 1'b0;

    // signed conditions with N=1, V=0
    drive(1'b1, 4'hE, 2'b11, 4'b1000);
    tick(); e_exec++;
    chk("sgn.flags", 16'(oFlags), 16'h8);
    drive(1'b0, 4'hA, 2'b00, 4'h0);
    chk("sgn.ge", 16'(oCondEx), 16'h0);
    drive(1'b0, 4'hB, 2'b00, 4'h0);
    chk("sgn.lt", 16'(oCondEx), 16'h1);
    drive(1'b0, 4'hC, 2'b00, 4'h0);
    chk("sgn.gt", 16'(oCondEx), 16'h0);
    drive(1'b0, 4'hD, 2'b00, 4'h0);
    chk("sgn.le", 16'(oCondEx), 16'h1);
    drive(1'b0, 4'h4, 2'b00, 4'h0);
    chk("sgn.mi", 16'(oCondEx), 16'h1);
    drive(1'b0, 4'h8, 2'b00, 4'h0);
    chk("sgn.hi", 16'(oCondEx), 16'h0);
    drive(1'b0, 4'h9, 2'b00, 4'h0);
    chk("sgn.ls", 16'(oCondEx), 16'h1);
    iRegW = 1'b1;
    drive(1'b1, 4'hF, 2'b11, 4'b0111);
    chk("nv.condex", 16'(oCondEx), 16'h0);
    chk("nv.regwrite", 16'(oRegWrite), 16'h0);
    tick(); e_skip++;
    chk("nv.flags", 16'(oFlags), 16'h8);
    chk_cnt("nv");
    iRegW = 1'b0;

    // reset mid-stream drops the pending flag write
    iRst = 1'b1;
    drive(1'b1, 4'hE, 2'b11, 4'b1111);
    tick(); e_exec = 0; e_skip = 0;
    iRst = 1'b0;
    chk("midrst.flags", 16'(oFlags), 16'h0);
    chk_cnt("midrst");

`ifdef COND_UNIT_STATS_EN
    drive(1'b1, 4'hE, 2'b00, 4'h0);
    for (int i = 0; i < 65535; i++) tick();
    e_exec = 65535;
    chk_cnt("sat.fill");
    tick();
    chk_cnt("sat.hold");
    drive(1'b1, 4'h0, 2'b00, 4'h0);
    tick(); e_skip++;
    chk_cnt("sat.skip");
    iStatClr = 1'b1;
    drive(1'b1, 4'h1, 2'b00, 4'h0);
    tick(); e_exec = 0; e_skip = 0;
    chk_cnt("statclr");
    iStatClr = 1'b0;
    drive(1'b1, 4'h1, 2'b00, 4'h0);
    tick(); e_exec++;
    chk_cnt("post_clr");
    iRst = 1'b1; iStatClr = 1'b1;
    drive(1'b1, 4'hE, 2'b11, 4'b1111);
    tick(); e_exec = 0; e_skip = 0;
    iRst = 1'b0; iStatClr = 1'b0;
    chk("rstclr.flags", 16'(oFlags), 16'h0);
    chk_cnt("rstclr");
`else
    iStatClr = 1'b1;
    drive(1'b1, 4'hE, 2'b00, 4'h0);
    tick();
    iStatClr = 1'b0;
    chk_cnt("nostats");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
